hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage core. It detects load-use hazards, branch-operand hazards for branches resolved in ID, and data-memory wait states. It drives the stall, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It complements the forwarding unit and covers the cases forwarding cannot resolve.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_fault is raised; range 2..255
CNT_W, 8, width of the wait counter and the perf counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rs1_ID  input  5  ID source register 1
rs2_ID  input  5  ID source register 2
use_rs1_ID  input  1  ID instruction reads rs1
use_rs2_ID  input  1  ID instruction reads rs2
branch_ID  input  1  ID holds a branch or JALR (operands needed in ID)
redirect_ID  input  1  ID resolved a taken branch or jump this cycle
rd_EX  input  5  EX destination register
MemRead_EX  input  1  EX instruction is a load
rd_MEM  input  5  MEM destination register
MemRead_MEM  input  1  MEM instruction is a load
mem_req_MEM  input  1  MEM stage accessing data memory
mem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
ifid_stall  output  1  hold IF/ID
ifid_flush  output  1  zero IF/ID (NOP)
idex_flush  output  1  insert bubble into ID/EX
exmem_stall  output  1  hold ID/EX and EX/MEM
memwb_flush  output  1  insert bubble into MEM/WB
mem_fault  output  1  one-cycle pulse on memory timeout

Behaviour:
- FSM states: RUN, STALL, MEM_WAIT. Registered state; outputs are Mealy (state plus current inputs).
- Reset: state=RUN, counters=0. All outputs read 0 in the reset cycle. rst asserted in any state forces RUN next cycle; an in-progress stall or wait is abandoned.
- Hazard terms, all requiring rd!=0:
  - lu = MemRead_EX && rd_EX matches a used ID source.
  - brEX = branch_ID && MemRead_EX && rd_EX matches a used ID source. Costs 2 stalls.
  - brMEM = branch_ID && MemRead_MEM && rd_MEM matches a used ID source. Costs 1 stall.
  - ALU producers are forwarded and cause no stall.
  - memw = mem_req_MEM && !mem_ready.
- Priority: memw > (brEX, brMEM, lu) > redirect_ID.
- RUN:
  - memw: go to MEM_WAIT. Assert pc_stall, ifid_stall, exmem_stall, memwb_flush.
  - Else brEX: assert pc_stall, ifid_stall, idex_flush. Go to STALL with scnt=1.
  - Else lu or brMEM: same outputs, 1 cycle, stay in RUN. Re-detection next cycle finds no hazard.
  - Else redirect_ID: ifid_flush=1.
- STALL:
  - Assert pc_stall, ifid_stall, idex_flush. scnt decrements; return to RUN when scnt==0 after the cycle.
  - memw in STALL takes priority: go to MEM_WAIT, keep scnt frozen, resume STALL afterwards.
- MEM_WAIT:
  - Hold the full freeze set. wcnt increments each cycle.
  - mem_ready=1: that cycle's outputs are still the freeze set; next cycle go to the return state.
  - wcnt reaches MEM_TIMEOUT-1 without ready: pulse mem_fault for 1 cycle, go to RUN, clear counters. The MEM instruction is dropped via memwb_flush.
- Flush gating: ifid_flush is never asserted in the same cycle as ifid_stall; redirect under stall waits until the stall releases. idex_flush and exmem_stall are never both 1; idex_flush is suppressed in MEM_WAIT.
- Counter width: wcnt is CNT_W bits and saturates; no wrap.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stall_cycles [CNT_W-1:0], flush_count [CNT_W-1:0] and wait_cycles [CNT_W-1:0].
  - stall_cycles increments per cycle with pc_stall=1 outside MEM_WAIT.
  - flush_count increments per ifid_flush.
  - wait_cycles increments per MEM_WAIT cycle.
  - All saturate at all-ones and clear on rst.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg: state enum (RUN=2'd0, STALL=2'd1, MEM_WAIT=2'd2), stall-length constants (BR_LOAD_EX_STALLS=2, LOAD_USE_STALLS=1), and a function src_match(rd, rs1, rs2, use1, use2).
- Sub-module hazard_detect: purely combinational, producing lu, brEX, brMEM and memw. The FSM and counters stay in hazard_controller.

Test Plan:
- Load-use: lw x5 in EX, add x6,x5,x1 in ID (use_rs1) -> 1 cycle with pc_stall=ifid_stall=idex_flush=1, then all 0.
- Branch after load: MemRead_EX, rd_EX=7, branch_ID on x7 -> 2 stall cycles; state RUN→STALL→RUN.
- rd=0 and ALU producer: rd_EX=0 with MemRead_EX, or an ALU write to a matching reg -> no stall outputs.
- Memory wait: mem_req_MEM=1, mem_ready low for 3 cycles -> freeze set held 4 cycles including the ready cycle, then RUN; mem_fault stays 0.
- Timeout plus redirect: MEM_TIMEOUT=4 with ready never asserted -> mem_fault pulses on cycle 4, state returns to RUN. Then redirect_ID=1 -> ifid_flush=1 for one cycle.
- Reset mid-STALL: rst asserted during STALL -> next cycle state is RUN and all outputs are 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types, stall-length constants and register-match helper for the
// pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   // Total cycles the front end is held for each hazard class.
   localparam int BR_LOAD_EX_STALLS = 2;
   localparam int LOAD_USE_STALLS   = 1;

   // Width of the STALL-state countdown; enough for the longest stall above.
   localparam int SCNT_W = 2;

   // True when a non-x0 producer register feeds a source the ID instruction reads.
   function automatic logic src_match(input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic       use1,
                                      input logic       use2);
      return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classification: load-use, branch operand waiting on a
// load in EX or MEM, and data-memory wait. No state lives here.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [4:0] rs1_id_i,
   input  logic [4:0] rs2_id_i,
   input  logic       use_rs1_id_i,
   input  logic       use_rs2_id_i,
   input  logic       branch_id_i,
   input  logic [4:0] rd_ex_i,
   input  logic       mem_read_ex_i,
   input  logic [4:0] rd_mem_i,
   input  logic       mem_read_mem_i,
   input  logic       mem_req_mem_i,
   input  logic       mem_ready_i,
   output logic       lu_o,
   output logic       br_ex_o,
   output logic       br_mem_o,
   output logic       memw_o
);

   logic ex_match;
   logic mem_match;

   assign ex_match  = src_match(rd_ex_i, rs1_id_i, rs2_id_i, use_rs1_id_i, use_rs2_id_i);
   assign mem_match = src_match(rd_mem_i, rs1_id_i, rs2_id_i, use_rs1_id_i, use_rs2_id_i);

   // Only loads stall; ALU producers are covered by the forwarding unit.
   assign lu_o     = mem_read_ex_i && ex_match;
   assign br_ex_o  = branch_id_i && mem_read_ex_i && ex_match;
   assign br_mem_o = branch_id_i && mem_read_mem_i && mem_match;
   assign memw_o   = mem_req_mem_i && !mem_ready_i;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: turns hazard classes into stall / flush /
// bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Outputs are Mealy
// (registered state plus current inputs) and read 0 while rst is high.
// Optional build macro HAZARD_PERF_EN adds saturating stall, flush and wait
// performance counters.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs1_ID,
   input  logic [4:0] rs2_ID,
   input  logic       use_rs1_ID,
   input  logic       use_rs2_ID,
   input  logic       branch_ID,
   input  logic       redirect_ID,
   input  logic [4:0] rd_EX,
   input  logic       MemRead_EX,
   input  logic [4:0] rd_MEM,
   input  logic       MemRead_MEM,
   input  logic       mem_req_MEM,
   input  logic       mem_ready,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_stall,
   output logic       memwb_flush,
   output logic       mem_fault
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] wait_cycles
`endif
);

   // Last wait-counter value at which a missing mem_ready becomes a fault.
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   state_t            state_q, state_d;
   state_t            ret_q, ret_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  wcnt_inc;

   logic lu, br_ex, br_mem, memw;
   logic hold;
   logic freeze;
   logic fault;

   hazard_detect u_detect (
      .rs1_id_i       (rs1_ID),
      .rs2_id_i       (rs2_ID),
      .use_rs1_id_i   (use_rs1_ID),
      .use_rs2_id_i   (use_rs2_ID),
      .branch_id_i    (branch_ID),
      .rd_ex_i        (rd_EX),
      .mem_read_ex_i  (MemRead_EX),
      .rd_mem_i       (rd_MEM),
      .mem_read_mem_i (MemRead_MEM),
      .mem_req_mem_i  (mem_req_MEM),
      .mem_ready_i    (mem_ready),
      .lu_o           (lu),
      .br_ex_o        (br_ex),
      .br_mem_o       (br_mem),
      .memw_o         (memw)
   );

   // Wait counter saturates rather than wrapping.
   assign wcnt_inc = (wcnt_q == {CNT_W{1'b1}}) ? wcnt_q : wcnt_q + CNT_W'(1);

   // State register, resume state and the two counters.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= RUN;
         ret_q   <= RUN;
         scnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         scnt_q  <= scnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next state plus the raw hold (front-end stall + bubble) and freeze
   // (whole-pipe hold for a memory wait) requests.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      state_d = state_q;
      ret_d   = ret_q;
      scnt_d  = scnt_q;
      wcnt_d  = wcnt_q;
      hold    = 1'b0;
      freeze  = 1'b0;
      fault   = 1'b0;

      case (state_q)
         RUN: begin
            if (memw) begin
               freeze  = 1'b1;
               ret_d   = RUN;
               state_d = MEM_WAIT;
               wcnt_d  = wcnt_inc;
            end else if (br_ex) begin
               hold    = 1'b1;
               scnt_d  = SCNT_W'(BR_LOAD_EX_STALLS - 1);
               state_d = STALL;
            end else if (lu || br_mem) begin
               // A single-cycle stall needs no counter: the hazard is gone
               // when detection runs again next cycle.
               hold = 1'b1;
               if (LOAD_USE_STALLS > 1) begin
                  scnt_d  = SCNT_W'(LOAD_USE_STALLS - 1);
                  state_d = STALL;
               end
            end
         end

         STALL: begin
            if (memw) begin
               // The countdown is frozen while memory holds the pipe.
               freeze  = 1'b1;
               ret_d   = STALL;
               state_d = MEM_WAIT;
               wcnt_d  = wcnt_inc;
            end else begin
               hold   = 1'b1;
               scnt_d = scnt_q - SCNT_W'(1);
               if (scnt_q <= SCNT_W'(1)) begin
                  state_d = RUN;
               end
            end
         end

         MEM_WAIT: begin
            freeze = 1'b1;
            if (mem_ready) begin
               state_d = ret_q;
               wcnt_d  = '0;
            end else if (wcnt_q >= WAIT_LIMIT) begin
               // Timeout: the stuck MEM instruction is dropped by the
               // MEM/WB bubble this cycle and any pending stall is abandoned.
               fault   = 1'b1;
               state_d = RUN;
               ret_d   = RUN;
               scnt_d  = '0;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_inc;
            end
         end

         default: begin
            state_d = RUN;
            ret_d   = RUN;
            scnt_d  = '0;
            wcnt_d  = '0;
         end
      endcase
   end

   // Output decode: a redirect waits while IF/ID is held, and the ID/EX
   // bubble never coincides with the EX/MEM hold. Everything is 0 in reset.
   always_comb begin
      pc_stall    = !rst && (hold || freeze);
      ifid_stall  = !rst && (hold || freeze);
      ifid_flush  = !rst && redirect_ID && !hold && !freeze;
      idex_flush  = !rst && hold && !freeze;
      exmem_stall = !rst && freeze;
      memwb_flush = !rst && freeze;
      mem_fault   = !rst && fault;
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_q;
   logic [CNT_W-1:0] flush_count_q;
   logic [CNT_W-1:0] wait_cycles_q;

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
         wait_cycles_q  <= '0;
      end else begin
         if (pc_stall && (state_q != MEM_WAIT) && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
         end
         if (ifid_flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_q <= flush_count_q + CNT_W'(1);
         end
         if ((state_q == MEM_WAIT) && (wait_cycles_q != {CNT_W{1'b1}})) begin
            wait_cycles_q <= wait_cycles_q + CNT_W'(1);
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign wait_cycles  = wait_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller built with MEM_TIMEOUT=4. Inputs change
// just after the falling edge; Mealy outputs are sampled 2 time units later.
module tb_hazard_controller;

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_STALL    = 2'd1;
   localparam logic [1:0] S_MEM_WAIT = 2'd2;

   // Output vector order:
   // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_flush, mem_fault}
   localparam logic [6:0] NONE     = 7'b0000000;
   localparam logic [6:0] STALLSET = 7'b1101000;
   localparam logic [6:0] FREEZE   = 7'b1100110;
   localparam logic [6:0] FAULT    = 7'b1100111;
   localparam logic [6:0] FLUSH    = 7'b0010000;

   logic       clk;
   logic       rst;
   logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
   logic       use_rs1_ID, use_rs2_ID, branch_ID, redirect_ID;
   logic       MemRead_EX, MemRead_MEM, mem_req_MEM, mem_ready;
   logic       pc_stall, ifid_stall, ifid_flush, idex_flush;
   logic       exmem_stall, memwb_flush, mem_fault;
`ifdef HAZARD_PERF_EN
   logic [7:0] stall_cycles, flush_count, wait_cycles;
`endif
   logic [6:0] outs;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .rs1_ID      (rs1_ID),
      .rs2_ID      (rs2_ID),
      .use_rs1_ID  (use_rs1_ID),
      .use_rs2_ID  (use_rs2_ID),
      .branch_ID   (branch_ID),
      .redirect_ID (redirect_ID),
      .rd_EX       (rd_EX),
      .MemRead_EX  (MemRead_EX),
      .rd_MEM      (rd_MEM),
      .MemRead_MEM (MemRead_MEM),
      .mem_req_MEM (mem_req_MEM),
      .mem_ready   (mem_ready),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_stall (exmem_stall),
      .memwb_flush (memwb_flush),
      .mem_fault   (mem_fault)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_count (flush_count),
      .wait_cycles (wait_cycles)
`endif
   );

   assign outs = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_flush, mem_fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample this cycle's outputs, then move to the next falling edge.
   task automatic step(input string tag, input logic [6:0] exp_o);
      #2;
      check(tag, 32'(outs), 32'(exp_o));
      @(negedge clk);
   endtask

   task automatic st(input string tag, input logic [1:0] exp_s);
      check(tag, 32'(dut.state_q), 32'(exp_s));
   endtask

   task automatic idle();
      rst         = 1'b0;
      rs1_ID      = 5'd0;
      rs2_ID      = 5'd0;
      use_rs1_ID  = 1'b0;
      use_rs2_ID  = 1'b0;
      branch_ID   = 1'b0;
      redirect_ID = 1'b0;
      rd_EX       = 5'd0;
      MemRead_EX  = 1'b0;
      rd_MEM      = 5'd0;
      MemRead_MEM = 1'b0;
      mem_req_MEM = 1'b0;
      mem_ready   = 1'b0;
   endtask

   task automatic load_branch_x7();
      MemRead_EX = 1'b1; rd_EX = 5'd7; branch_ID = 1'b1;
      rs1_ID = 5'd7; use_rs1_ID = 1'b1; rs2_ID = 5'd8; use_rs2_ID = 1'b1;
   endtask

   initial begin
      // Reset with every hazard present: outputs must still read 0.
      idle();
      rst = 1'b1; MemRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
      mem_req_MEM = 1'b1; redirect_ID = 1'b1;
      @(negedge clk);
      step("reset_outs", NONE);
      idle();
      st("reset_state", S_RUN);
      step("idle_outs", NONE);

      // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
      MemRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
      rs2_ID = 5'd1; use_rs2_ID = 1'b1;
      step("lu_stall", STALLSET);
      st("lu_state", S_RUN);
      MemRead_EX = 1'b0; rd_EX = 5'd0; MemRead_MEM = 1'b1; rd_MEM = 5'd5;
      step("lu_release", NONE);
      idle();

      // Redirect under a load-use stall is held off, then taken.
      MemRead_EX = 1'b1; rd_EX = 5'd3; rs2_ID = 5'd3; use_rs2_ID = 1'b1; redirect_ID = 1'b1;
      step("lu_redir_gate", STALLSET);
      MemRead_EX = 1'b0; rd_EX = 5'd0;
      step("redir_after_stall", FLUSH);
      idle();

      // Branch on x7 with the load of x7 in EX: two stall cycles.
      load_branch_x7();
      step("brex_c1", STALLSET);
      st("brex_state_stall", S_STALL);
      MemRead_EX = 1'b0; rd_EX = 5'd0; MemRead_MEM = 1'b1; rd_MEM = 5'd7;
      step("brex_c2", STALLSET);
      st("brex_state_run", S_RUN);
      MemRead_MEM = 1'b0; rd_MEM = 5'd0; redirect_ID = 1'b1;
      step("brex_resolve", FLUSH);
      idle();
      step("brex_done", NONE);

      // Branch with the load in MEM: one stall cycle.
      branch_ID = 1'b1; MemRead_MEM = 1'b1; rd_MEM = 5'd9; rs2_ID = 5'd9; use_rs2_ID = 1'b1;
      step("brmem_stall", STALLSET);
      st("brmem_state", S_RUN);
      MemRead_MEM = 1'b0; rd_MEM = 5'd0;
      step("brmem_release", NONE);
      idle();

      // No-stall cases: x0 load target, ALU producers, unused sources.
      MemRead_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; use_rs1_ID = 1'b1;
      step("rd0_load", NONE);
      MemRead_EX = 1'b0; rd_EX = 5'd6; rs1_ID = 5'd6;
      step("alu_fwd", NONE);
      MemRead_EX = 1'b1; rd_EX = 5'd6; rs1_ID = 5'd6; use_rs1_ID = 1'b0;
      rs2_ID = 5'd6; use_rs2_ID = 1'b0;
      step("unused_src", NONE);
      idle();
      branch_ID = 1'b1; rd_EX = 5'd6; rd_MEM = 5'd6; rs1_ID = 5'd6; use_rs1_ID = 1'b1;
      step("br_alu", NONE);
      idle();

      // Memory wait: ready low 3 cycles, freeze held 4 including the ready cycle.
      mem_req_MEM = 1'b1;
      step("mw_c1", FREEZE);
      st("mw_state", S_MEM_WAIT);
      redirect_ID = 1'b1;
      step("mw_c2", FREEZE);
      step("mw_c3", FREEZE);
      mem_ready = 1'b1;
      step("mw_ready", FREEZE);
      st("mw_ret", S_RUN);
      idle();
      step("mw_after", NONE);

      // Timeout with MEM_TIMEOUT=4: fault on the fourth frozen cycle.
      mem_req_MEM = 1'b1;
      step("to_c1", FREEZE);
      step("to_c2", FREEZE);
      step("to_c3", FREEZE);
      step("to_fault", FAULT);
      st("to_state", S_RUN);
      mem_req_MEM = 1'b0; redirect_ID = 1'b1;
      step("to_redirect", FLUSH);
      idle();
      step("to_quiet", NONE);

      // Memory wait inside STALL: countdown frozen, STALL resumed afterwards.
      load_branch_x7();
      step("sw_c1", STALLSET);
      MemRead_EX = 1'b0; rd_EX = 5'd0; mem_req_MEM = 1'b1;
      step("sw_freeze", FREEZE);
      st("sw_state", S_MEM_WAIT);
      mem_ready = 1'b1;
      step("sw_ready", FREEZE);
      st("sw_resume", S_STALL);
      mem_req_MEM = 1'b0; mem_ready = 1'b0;
      step("sw_stall2", STALLSET);
      st("sw_run", S_RUN);
      idle();
      step("sw_done", NONE);

      // Reset asserted mid-STALL.
      load_branch_x7();
      step("rs_c1", STALLSET);
      st("rs_stall", S_STALL);
      rst = 1'b1;
      step("rs_outs", NONE);
      idle();
      st("rs_state", S_RUN);
      step("rs_after", NONE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
